// File: rtl/phys_reg_free_list.sv
// phys_reg_free_list: circular FIFO of free physical registers; dispatch pops, flush/retire push back.
module phys_reg_free_list #(
  parameter int PR_W = 6,
  parameter int NUM_ARCH = 32,
  parameter int DEPTH = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            isDispatch,
  input  logic            RegDest,
  input  logic            hazard_stall,
  output logic [PR_W-1:0] PR_new,
  output logic            empty,
  input  logic            retire_reg,
  input  logic            RegDest_retire,
  input  logic [PR_W-1:0] PR_old_RT,
  input  logic            recover,
  input  logic            RegDest_out,
  input  logic [PR_W-1:0] PR_new_flush,
  output logic [PR_W-1:0] free_count,
  output logic            overflow
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = PR_W + 1;
  logic [PR_W-1:0] entry [DEPTH];
  logic [AW-1:0] head, tail;
  logic [PR_W-1:0] count;
  logic pop, push_a, push_b, acc_a, acc_b, drop;
  logic [CW-1:0] base;
  assign empty = count == '0;
  assign free_count = count;
  assign PR_new = entry[head];
  assign pop = isDispatch & RegDest & ~hazard_stall & ~recover & ~empty;
  assign push_a = recover & RegDest_out;
  assign push_b = retire_reg & RegDest_retire;
  // Flush push has priority for the last free slot; retire is dropped first.
  always_comb begin
    base = {1'b0, count} - CW'(pop);
    acc_a = push_a && base < CW'(DEPTH);
    acc_b = push_b && (base + CW'(acc_a)) < CW'(DEPTH);
    drop = (push_a & ~acc_a) | (push_b & ~acc_b);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) entry[i] <= PR_W'(NUM_ARCH + i);
      head <= '0;
      tail <= '0;
      count <= PR_W'(DEPTH);
      overflow <= 1'b0;
    end else begin
      if (acc_a) entry[tail] <= PR_new_flush;
      if (acc_b) entry[tail + AW'(acc_a)] <= PR_old_RT;
      head <= head + AW'(pop);
      tail <= tail + AW'(acc_a) + AW'(acc_b);
      count <= PR_W'(base + CW'(acc_a) + CW'(acc_b));
      if (drop) overflow <= 1'b1;
    end
  end
endmodule

// File: tb/tb_phys_reg_free_list.sv
// tb_phys_reg_free_list: directed checks of pop/push ordering, empty, overflow and reset, plus a queue-modelled wrap run.
module tb_phys_reg_free_list;
  logic clk = 0, rst = 1;
  logic isDispatch = 0, RegDest = 0, hazard_stall = 0;
  logic retire_reg = 0, RegDest_retire = 0, recover = 0, RegDest_out = 0;
  logic [5:0] PR_old_RT = 0, PR_new_flush = 0;
  logic [5:0] PR_new, free_count;
  logic empty, overflow;
  int vectors = 0, miscompares = 0;
  logic [5:0] exp_seq [32];
  logic [5:0] q [$];

  phys_reg_free_list dut (
    .clk(clk), .rst(rst), .isDispatch(isDispatch), .RegDest(RegDest),
    .hazard_stall(hazard_stall), .PR_new(PR_new), .empty(empty),
    .retire_reg(retire_reg), .RegDest_retire(RegDest_retire), .PR_old_RT(PR_old_RT),
    .recover(recover), .RegDest_out(RegDest_out), .PR_new_flush(PR_new_flush),
    .free_count(free_count), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    isDispatch = 0; RegDest = 0; hazard_stall = 0; retire_reg = 0; RegDest_retire = 0;
    recover = 0; RegDest_out = 0; PR_old_RT = 0; PR_new_flush = 0;
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_pr"}, PR_new, 32'h20);
    chk({tag, "_fc"}, free_count, 32);
    chk({tag, "_empty"}, empty, 0);
    chk({tag, "_ovf"}, overflow, 0);
  endtask

  initial begin
    step();
    rst = 0;
    step();
    step();
    chk_reset("reset");
    isDispatch = 1; RegDest = 1;
    for (int i = 0; i < 3; i++) begin
      chk("pop3_pr", PR_new, 32'h20 + i);
      step();
    end
    idle();
    chk("pop3_after_pr", PR_new, 32'h23);
    chk("pop3_after_fc", free_count, 29);
    isDispatch = 1; RegDest = 0;
    step();
    chk("nodest_pr", PR_new, 32'h23);
    chk("nodest_fc", free_count, 29);
    RegDest = 1; hazard_stall = 1;
    step();
    chk("stall_pr", PR_new, 32'h23);
    chk("stall_fc", free_count, 29);
    hazard_stall = 0; recover = 1;
    step();
    chk("recover_blocks_pop_fc", free_count, 29);
    RegDest_out = 1; PR_new_flush = 6'h25;
    retire_reg = 1; RegDest_retire = 1; PR_old_RT = 6'h02;
    step();
    idle();
    chk("dual_push_fc", free_count, 31);
    chk("dual_push_pr", PR_new, 32'h23);
    retire_reg = 1; RegDest_retire = 1; PR_old_RT = 6'h11;
    step();
    chk("fill_fc", free_count, 32);
    chk("fill_ovf", overflow, 0);
    PR_old_RT = 6'h05;
    step();
    idle();
    chk("ovf_set", overflow, 1);
    chk("ovf_fc", free_count, 32);
    step();
    chk("ovf_sticky", overflow, 1);
    for (int i = 0; i < 29; i++) exp_seq[i] = 6'(8'h23 + i);
    exp_seq[29] = 6'h25; exp_seq[30] = 6'h02; exp_seq[31] = 6'h11;
    isDispatch = 1; RegDest = 1;
    for (int i = 0; i < 32; i++) begin
      chk("drain_pr", PR_new, exp_seq[i]);
      step();
    end
    chk("drained_empty", empty, 1);
    chk("drained_fc", free_count, 0);
    chk("drained_ovf", overflow, 1);
    retire_reg = 1; RegDest_retire = 1; PR_old_RT = 6'h01;
    step();
    idle();
    chk("nobypass_empty", empty, 0);
    chk("nobypass_pr", PR_new, 32'h01);
    chk("nobypass_fc", free_count, 1);
    q.push_back(6'h01);
    for (int c = 0; c < 100; c++) begin
      logic p, pa, pb;
      int base;
      isDispatch = 1;
      RegDest = $urandom_range(0, 3) != 0;
      hazard_stall = $urandom_range(0, 7) == 0;
      recover = $urandom_range(0, 7) == 0;
      RegDest_out = 1'($urandom_range(0, 1));
      PR_new_flush = 6'($urandom);
      retire_reg = 1'($urandom_range(0, 1));
      RegDest_retire = 1;
      PR_old_RT = 6'($urandom);
      chk("wrap_fc", free_count, q.size());
      chk("wrap_empty", empty, q.size() == 0);
      if (q.size() > 0) chk("wrap_pr", PR_new, q[0]);
      p = isDispatch & RegDest & ~hazard_stall & ~recover & (q.size() > 0);
      pa = recover & RegDest_out;
      pb = retire_reg & RegDest_retire;
      if (p) void'(q.pop_front());
      base = q.size();
      if (pa && base < 32) q.push_back(PR_new_flush);
      if (pb && q.size() < 32) q.push_back(PR_old_RT);
      step();
    end
    chk("wrap_end_fc", free_count, q.size());
    isDispatch = 1; RegDest = 1; retire_reg = 1; RegDest_retire = 1; PR_old_RT = 6'h3a;
    rst = 1;
    step();
    rst = 0;
    idle();
    chk_reset("midrst");
    step();
    chk_reset("midrst_idle");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
